wb_register_file: RTL and testbench

- 32 x 32-bit MIPS general-purpose register file; the consumer of the stage-five writeback bus (write data, write enable, destination register).
- Serves the two decode-stage read ports (rs, rt).
- After every reset, a built-in init sequencer clears all registers one per cycle before normal operation is allowed.
- $zero is hardwired to 0.

---
 rtl/wb_register_file.sv | 129 ++++++++++++
 tb/tb_wb_register_file.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_register_file.sv
// 32 x 32-bit MIPS register file with writeback write port, two async read ports and a post-reset clear sequencer.
// Optional build macro WB_BYPASS_EN: same-cycle write-first bypass from the writeback bus to both read ports.
module wb_register_file #(
    parameter int               DATA_W     = 32,
    parameter int               ADDR_W     = 5,
    parameter logic [DATA_W-1:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_regwrite,
    input  logic [ADDR_W-1:0] wb_writereg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              init_busy,
    output logic [15:0]       wr_count
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  idx;
    logic [ADDR_W-1:0]  idx_next;

    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;
    logic               count_en;
    logic               run_active;

    logic [DATA_W-1:0]  mem [DEPTH];

    assign run_active = rst_n && (state == ST_RUN);
    assign init_busy  = !run_active;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            idx      <= '0;
            wr_count <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (count_en && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        mem_we     = 1'b0;
        mem_waddr  = idx;
        mem_wdata  = INIT_VALUE;
        count_en   = 1'b0;
        case (state)
            ST_INIT: begin
                mem_we   = 1'b1;
                idx_next = idx + 1'b1;
                if (idx == LAST_IDX) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wb_regwrite && (wb_writereg != '0)) begin
                    mem_we    = 1'b1;
                    mem_waddr = wb_writereg;
                    mem_wdata = wb_data;
                    count_en  = 1'b1;
                end
            end
            default: begin
                state_next = ST_INIT;
                idx_next   = '0;
            end
        endcase
    end

    // NOTE: storage has no reset; the init sequencer clears it, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic              active,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] value;
        value = stored;
`ifdef WB_BYPASS_EN
        // Write-first: the word landing this edge is forwarded straight to decode.
        if (we && (waddr != '0) && (addr == waddr)) begin
            value = wdata;
        end
`else
        if (we && (waddr != '0) && (addr == waddr)) begin
            value = stored;
        end
`endif
        if (!active || (addr == '0)) begin
            value = '0;
        end
        return value;
    endfunction

    always_comb begin
        rs_data = read_port(run_active, rs_addr, mem[rs_addr], wb_regwrite, wb_writereg, wb_data);
        rt_data = read_port(run_active, rt_addr, mem[rt_addr], wb_regwrite, wb_writereg, wb_data);
    end

endmodule

// File: tb/tb_wb_register_file.sv
// Directed self-checking bench for wb_register_file; expectations follow the WB_BYPASS_EN build setting.
module tb_wb_register_file;

    logic        clk;
    logic        rst_n;
    logic        wb_regwrite;
    logic [4:0]  wb_writereg;
    logic [31:0] wb_data;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        init_busy;
    logic [15:0] wr_count;

    int checks = 0;
    int errors = 0;

    wb_register_file dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_regwrite (wb_regwrite),
        .wb_writereg (wb_writereg),
        .wb_data     (wb_data),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .init_busy   (init_busy),
        .wr_count    (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        wb_regwrite = 1'b1;
        wb_writereg = addr;
        wb_data     = data;
        @(posedge clk);
        #1;
        wb_regwrite = 1'b0;
    endtask

    // Releases reset and expects init_busy high for exactly 32 edges, then low.
    task automatic run_init(input int inject_cycle);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1;
            checks++;
            if (init_busy !== 1'b1) begin
                errors++;
                $display("FAIL init_busy_during_init cycle %0d: got %b expected 1", i, init_busy);
            end
            checks++;
            if (rs_data !== 32'h0) begin
                errors++;
                $display("FAIL rs_zero_during_init cycle %0d: got %h expected 0", i, rs_data);
            end
            if (i == inject_cycle) begin
                wb_regwrite = 1'b1;
                wb_writereg = 5'd9;
                wb_data     = 32'h55;
            end else begin
                wb_regwrite = 1'b0;
            end
            @(negedge clk);
        end
        wb_regwrite = 1'b0;
        #1;
        checks++;
        if (init_busy !== 1'b0) begin
            errors++;
            $display("FAIL init_busy_after_init: got %b expected 0", init_busy);
        end
        checks++;
        if (wr_count !== 16'd0) begin
            errors++;
            $display("FAIL wr_count_after_init: got %0d expected 0", wr_count);
        end
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        wb_regwrite = 1'b0;
        wb_writereg = '0;
        wb_data     = '0;
        rs_addr     = 5'd1;
        rt_addr     = 5'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (init_busy !== 1'b1) begin
            errors++;
            $display("FAIL init_busy_in_reset: got %b expected 1", init_busy);
        end
        checks++;
        if (wr_count !== 16'd0) begin
            errors++;
            $display("FAIL wr_count_in_reset: got %0d expected 0", wr_count);
        end
        run_init(-1);
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a);
            rt_addr = 5'(31 - a);
            #1;
            checks++;
            if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
                errors++;
                $display("FAIL cleared_reg %0d: rs=%h rt=%h expected 0", a, rs_data, rt_data);
            end
        end
    endtask

    task automatic test_basic_rw;
        do_write(5'd5, 32'hDEADBEEF);
        do_write(5'd31, 32'h12345678);
        @(negedge clk);
        rs_addr = 5'd5;
        rt_addr = 5'd31;
        #1;
        checks++;
        if (rs_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_rs_reg5: got %h expected deadbeef", rs_data);
        end
        checks++;
        if (rt_data !== 32'h12345678) begin
            errors++;
            $display("FAIL basic_rt_reg31: got %h expected 12345678", rt_data);
        end
        checks++;
        if (wr_count !== 16'd2) begin
            errors++;
            $display("FAIL basic_wr_count: got %0d expected 2", wr_count);
        end
        rs_addr = 5'd31;
        rt_addr = 5'd31;
        #1;
        checks++;
        if (rs_data !== 32'h12345678 || rt_data !== 32'h12345678) begin
            errors++;
            $display("FAIL same_reg_both_ports: rs=%h rt=%h expected 12345678", rs_data, rt_data);
        end
    endtask

    task automatic test_zero_reg;
        do_write(5'd0, 32'hFFFFFFFF);
        @(negedge clk);
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        #1;
        checks++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
            errors++;
            $display("FAIL zero_reg_read: rs=%h rt=%h expected 0", rs_data, rt_data);
        end
        checks++;
        if (wr_count !== 16'd2) begin
            errors++;
            $display("FAIL zero_reg_wr_count: got %0d expected 2", wr_count);
        end
    endtask

    task automatic test_hazard;
        logic [31:0] exp_same;
`ifdef WB_BYPASS_EN
        exp_same = 32'hA5A5A5A5;
`else
        exp_same = 32'h00000001;
`endif
        do_write(5'd7, 32'h1);
        @(negedge clk);
        rs_addr     = 5'd7;
        rt_addr     = 5'd7;
        wb_regwrite = 1'b1;
        wb_writereg = 5'd7;
        wb_data     = 32'hA5A5A5A5;
        #1;
        checks++;
        if (rs_data !== exp_same || rt_data !== exp_same) begin
            errors++;
            $display("FAIL hazard_same_cycle: rs=%h rt=%h expected %h", rs_data, rt_data, exp_same);
        end
        @(posedge clk);
        #1;
        wb_regwrite = 1'b0;
        @(negedge clk);
        checks++;
        if (rs_data !== 32'hA5A5A5A5 || rt_data !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL hazard_next_cycle: rs=%h rt=%h expected a5a5a5a5", rs_data, rt_data);
        end
        checks++;
        if (wr_count !== 16'd4) begin
            errors++;
            $display("FAIL hazard_wr_count: got %0d expected 4", wr_count);
        end
    endtask

    task automatic test_init_write;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        run_init(20);
        rs_addr = 5'd9;
        rt_addr = 5'd5;
        #1;
        checks++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
            errors++;
            $display("FAIL init_write_dropped: reg9=%h reg5=%h expected 0", rs_data, rt_data);
        end
    endtask

    task automatic test_mid_run_reset;
        do_write(5'd3, 32'h77);
        @(negedge clk);
        rs_addr = 5'd3;
        #1;
        checks++;
        if (rs_data !== 32'h77 || wr_count !== 16'd1) begin
            errors++;
            $display("FAIL pre_reset_reg3: got %h count %0d expected 77 count 1", rs_data, wr_count);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (init_busy !== 1'b1 || rs_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_immediate_busy: busy=%b rs=%h expected 1 and 0", init_busy, rs_data);
        end
        @(posedge clk);
        run_init(-1);
        rs_addr = 5'd3;
        #1;
        checks++;
        if (rs_data !== 32'h0) begin
            errors++;
            $display("FAIL reg3_after_reset: got %h expected 0", rs_data);
        end
    endtask

    initial begin
        test_reset;
        test_basic_rw;
        test_zero_reg;
        test_hazard;
        test_init_write;
        test_mid_run_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
